uart_time_loader: RTL and testbench

//  Reads a time-set frame from the UART RX FIFO: "T" h h ":" m m ":" s s <CR|LF>.

---
 rtl/uart_time_loader_if.sv | 38 +++
 rtl/uart_time_loader.sv | 173 +++++++++++++++++
 tb/tb_uart_time_loader.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_time_loader_if.sv
// Bundle between the UART RX FIFO pop port, the time-set frame loader and the watch counters.
//   empty     : RX FIFO empty flag
//   pop_data  : RX FIFO head byte, valid whenever empty == 0 (first-word-fall-through)
//   pop       : consume the head byte this cycle
//   load      : one-cycle strobe, load_hour/min/sec valid for the watch
//   load_hour : parsed hour 0..23
//   load_min  : parsed minute 0..59
//   load_sec  : parsed second 0..59
// master = the loader (drives pop and load*), slave = FIFO/watch side.
interface uart_time_loader_if;
    logic       empty;
    logic [7:0] pop_data;
    logic       pop;
    logic       load;
    logic [4:0] load_hour;
    logic [5:0] load_min;
    logic [5:0] load_sec;

    modport master (
        input  empty,
        input  pop_data,
        output pop,
        output load,
        output load_hour,
        output load_min,
        output load_sec
    );

    modport slave (
        output empty,
        output pop_data,
        input  pop,
        input  load,
        input  load_hour,
        input  load_min,
        input  load_sec
    );
endinterface

// File: rtl/uart_time_loader.sv
// Receives a time-set frame "T" h h ":" m m ":" s s <CR|LF> from the UART RX FIFO, validates
// every byte as it is popped, stages the parsed hour/minute/second and fires a one-cycle load
// strobe towards the watch counters once the terminator arrives.
//   clk       : system clock
//   reset     : asynchronous, active-high reset
//   bus_io    : FIFO pop port and watch load port (see uart_time_loader_if)
//   frame_err : one-cycle strobe, frame aborted (bad char, out of range, inter-byte timeout)
//   busy      : high while a frame is in progress
module uart_time_loader #(
    parameter logic [7:0]  HEADER         = 8'h54,
    parameter int unsigned TIMEOUT_CYCLES = 10_000_000
) (
    input  logic               clk,
    input  logic               reset,
    uart_time_loader_if.master bus_io,
    output logic               frame_err,
    output logic               busy
);

    localparam int unsigned     CntW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [3:0] {
        StIdle, StHt, StHu, StC1, StMt, StMu, StC2, StSt, StSu, StTerm, StLoad, StErr
    } state_e;

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic [3:0]      tens_q;
    logic [4:0]      hour_q;
    logic [5:0]      min_q;
    logic [5:0]      sec_q;
    logic            load_q;
    logic            frame_err_q;
    logic [4:0]      load_hour_q;
    logic [5:0]      load_min_q;
    logic [5:0]      load_sec_q;

    logic            pop;
    logic [3:0]      digit;
    logic            is_digit;
    logic [6:0]      value;
    logic            byte_ok;
    state_e          adv_st;

    // Byte classification for the current state; evaluated in the cycle the byte is popped.
    always_comb begin
        is_digit = (bus_io.pop_data >= 8'h30) && (bus_io.pop_data <= 8'h39);
        // For '0'..'9' the low nibble equals byte - 8'h30.
        digit    = bus_io.pop_data[3:0];
        // tens*10 + units without a multiplier
        value    = ({3'b000, tens_q} << 3) + ({3'b000, tens_q} << 1) + {3'b000, digit};
        byte_ok  = 1'b0;
        adv_st   = StIdle;
        case (state_q)
            StHt: begin
                byte_ok = is_digit && (digit <= 4'd2);
                adv_st  = StHu;
            end
            StHu: begin
                byte_ok = is_digit && (value <= 7'd23);
                adv_st  = StC1;
            end
            StC1: begin
                byte_ok = (bus_io.pop_data == 8'h3A);
                adv_st  = StMt;
            end
            StMt: begin
                byte_ok = is_digit && (digit <= 4'd5);
                adv_st  = StMu;
            end
            StMu: begin
                byte_ok = is_digit;
                adv_st  = StC2;
            end
            StC2: begin
                byte_ok = (bus_io.pop_data == 8'h3A);
                adv_st  = StSt;
            end
            StSt: begin
                byte_ok = is_digit && (digit <= 4'd5);
                adv_st  = StSu;
            end
            StSu: begin
                byte_ok = is_digit;
                adv_st  = StTerm;
            end
            StTerm: begin
                byte_ok = (bus_io.pop_data == 8'h0D) || (bus_io.pop_data == 8'h0A);
                adv_st  = StLoad;
            end
            default: begin
                byte_ok = 1'b0;
                adv_st  = StIdle;
            end
        endcase
        pop = !bus_io.empty && (state_q != StLoad) && (state_q != StErr);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            tens_q      <= '0;
            hour_q      <= '0;
            min_q       <= '0;
            sec_q       <= '0;
            load_q      <= 1'b0;
            frame_err_q <= 1'b0;
            load_hour_q <= '0;
            load_min_q  <= '0;
            load_sec_q  <= '0;
        end else begin
            load_q      <= 1'b0;
            frame_err_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    cnt_q <= '0;
                    // Non-header bytes are dropped without an error.
                    if (pop && (bus_io.pop_data == HEADER)) begin
                        state_q <= StHt;
                    end
                end
                StLoad, StErr: begin
                    cnt_q   <= '0;
                    state_q <= StIdle;
                end
                default: begin
                    // A popped byte takes priority over an expiring timeout.
                    if (pop) begin
                        cnt_q <= '0;
                        if (byte_ok) begin
                            state_q <= adv_st;
                            case (state_q)
                                StHt, StMt, StSt: tens_q <= digit;
                                StHu:             hour_q <= value[4:0];
                                StMu:             min_q  <= value[5:0];
                                StSu:             sec_q  <= value[5:0];
                                StTerm: begin
                                    load_q      <= 1'b1;
                                    load_hour_q <= hour_q;
                                    load_min_q  <= min_q;
                                    load_sec_q  <= sec_q;
                                end
                                default: ;
                            endcase
                        end else if (bus_io.pop_data == HEADER) begin
                            // Resync on a stray header instead of flagging an error.
                            state_q <= StHt;
                        end else begin
                            state_q     <= StErr;
                            frame_err_q <= 1'b1;
                        end
                    end else if (cnt_q == CntLast) begin
                        state_q     <= StErr;
                        frame_err_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
            endcase
        end
    end

    assign bus_io.pop       = pop;
    assign bus_io.load      = load_q;
    assign bus_io.load_hour = load_hour_q;
    assign bus_io.load_min  = load_min_q;
    assign bus_io.load_sec  = load_sec_q;
    assign frame_err        = frame_err_q;
    assign busy             = (state_q != StIdle);

endmodule

// File: tb/tb_uart_time_loader.sv
module tb_uart_time_loader;

    localparam int unsigned TO = 40;

    logic clk = 1'b0;
    logic reset;
    logic frame_err;
    logic busy;

    uart_time_loader_if bus ();

    uart_time_loader #(
        .HEADER        (8'h54),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus_io   (bus),
        .frame_err(frame_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int gap      = 0;
    int spacing  = 0;
    int last_pop_cyc = 0;
    int err_cyc      = 0;

    byte unsigned fifo[$];
    int           obs_ev[$];
    int           exp_ev[$];

    // Reference model state: bytes of the frame accepted so far (empty = hunting for header).
    byte unsigned m_buf[$];
    int           last_h = 0;
    int           last_m = 0;
    int           last_s = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Does this byte sequence (starting with the header) form a legal frame prefix?
    function automatic bit prefix_ok(input byte unsigned f[$]);
        int d;
        bit dig;
        for (int i = 1; i < f.size(); i++) begin
            d   = int'(f[i]) - 48;
            dig = (d >= 0) && (d <= 9);
            case (i)
                1:       if (!(dig && d <= 2)) return 1'b0;
                2:       if (!(dig && ((int'(f[1]) - 48) * 10 + d) <= 23)) return 1'b0;
                3, 6:    if (f[i] != 8'h3A) return 1'b0;
                4, 7:    if (!(dig && d <= 5)) return 1'b0;
                5, 8:    if (!dig) return 1'b0;
                9:       if (!(f[i] == 8'h0D || f[i] == 8'h0A)) return 1'b0;
                default: return 1'b0;
            endcase
        end
        return 1'b1;
    endfunction

    task automatic model_byte(input byte unsigned b);
        byte unsigned cand[$];
        int h, m, s;
        if (m_buf.size() == 0) begin
            if (b == 8'h54) m_buf.push_back(b);
            return;
        end
        cand = m_buf;
        cand.push_back(b);
        if (prefix_ok(cand)) begin
            if (cand.size() == 10) begin
                h = (int'(cand[1]) - 48) * 10 + (int'(cand[2]) - 48);
                m = (int'(cand[4]) - 48) * 10 + (int'(cand[5]) - 48);
                s = (int'(cand[7]) - 48) * 10 + (int'(cand[8]) - 48);
                exp_ev.push_back(h * 10000 + m * 100 + s);
                last_h = h;
                last_m = m;
                last_s = s;
                m_buf.delete();
            end else begin
                m_buf = cand;
            end
        end else if (b == 8'h54) begin
            m_buf.delete();
            m_buf.push_back(b);
        end else begin
            exp_ev.push_back(-1);
            m_buf.delete();
        end
    endtask

    task automatic push_byte(input byte unsigned b);
        fifo.push_back(b);
        model_byte(b);
    endtask

    task automatic send_str(input string s, input int sp);
        spacing = sp;
        for (int i = 0; i < s.len(); i++) push_byte(s[i]);
    endtask

    // One clock: present FIFO head, sample pop mid-cycle, then observe registered outputs.
    task automatic step();
        logic         popped;
        byte unsigned pbyte;
        if (gap > 0 || fifo.size() == 0) begin
            bus.empty    = 1'b1;
            bus.pop_data = 8'h00;
        end else begin
            bus.empty    = 1'b0;
            bus.pop_data = fifo[0];
        end
        @(negedge clk);
        check("pop_while_empty", {31'b0, bus.pop & bus.empty}, 32'd0);
        popped = (bus.pop === 1'b1);
        pbyte  = bus.pop_data;
        @(posedge clk);
        #1;
        cyc++;
        if (popped) begin
            void'(fifo.pop_front());
            gap          = spacing;
            last_pop_cyc = cyc;
        end else if (gap > 0) begin
            gap--;
        end
        if (bus.load === 1'b1) begin
            check("load_after_term_pop",
                  {31'b0, popped && (pbyte == 8'h0D || pbyte == 8'h0A)}, 32'd1);
            obs_ev.push_back(int'(bus.load_hour) * 10000 + int'(bus.load_min) * 100
                             + int'(bus.load_sec));
        end
        if (frame_err === 1'b1) begin
            obs_ev.push_back(-1);
            err_cyc = cyc;
        end
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((fifo.size() != 0 || gap != 0) && n < 5000) begin
            step();
            n++;
        end
        if (n >= 5000) check({tag, "/drain_timeout"}, 32'd1, 32'd0);
    endtask

    // Let any partial frame time out, then compare the event stream with the model.
    task automatic finish_scn(input string tag);
        for (int i = 0; i < TO + 6; i++) step();
        if (m_buf.size() != 0) begin
            exp_ev.push_back(-1);
            m_buf.delete();
        end
        check({tag, "/n_events"}, obs_ev.size(), exp_ev.size());
        for (int i = 0; i < obs_ev.size() && i < exp_ev.size(); i++) begin
            check($sformatf("%s/event%0d", tag, i), obs_ev[i], exp_ev[i]);
        end
        check({tag, "/busy_idle"}, {31'b0, busy}, 32'd0);
        check({tag, "/load_hour"}, {27'b0, bus.load_hour}, last_h);
        check({tag, "/load_min"}, {26'b0, bus.load_min}, last_m);
        check({tag, "/load_sec"}, {26'b0, bus.load_sec}, last_s);
        obs_ev.delete();
        exp_ev.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "/pop"}, {31'b0, bus.pop}, 32'd0);
        check({tag, "/load"}, {31'b0, bus.load}, 32'd0);
        check({tag, "/frame_err"}, {31'b0, frame_err}, 32'd0);
        check({tag, "/busy"}, {31'b0, busy}, 32'd0);
        check({tag, "/load_hour"}, {27'b0, bus.load_hour}, 32'd0);
        check({tag, "/load_min"}, {26'b0, bus.load_min}, 32'd0);
        check({tag, "/load_sec"}, {26'b0, bus.load_sec}, 32'd0);
    endtask

    initial begin
        byte unsigned pool[8];
        byte unsigned frm[10];
        int h, m, s, delay;

        pool = '{8'h30, 8'h39, 8'h3A, 8'h54, 8'h61, 8'h0D, 8'h0A, 8'h37};

        reset        = 1'b1;
        bus.empty    = 1'b1;
        bus.pop_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset = 1'b0;

        // Basic frame
        send_str("T12:34:56\015", 0);
        drain("basic");
        finish_scn("basic");

        // Hour out of range; trailing bytes dropped while idle
        send_str("T24:00:00\015", 0);
        drain("hour24");
        finish_scn("hour24");

        // Garbage before header, LF terminator, bytes spaced out
        send_str("xyT01:02:03\n", 5);
        drain("spaced");
        finish_scn("spaced");

        // Resync on a second header
        send_str("T1T23:59:59\015", 1);
        drain("resync");
        finish_scn("resync");

        // Inter-byte timeout mid-frame
        send_str("T12:", 0);
        drain("timeout");
        repeat (3) step();
        check("timeout/busy_mid", {31'b0, busy}, 32'd1);
        err_cyc = 0;
        finish_scn("timeout");
        delay = err_cyc - last_pop_cyc;
        check("timeout/delay_window", {31'b0, (delay >= int'(TO) - 1) && (delay <= int'(TO) + 1)},
              32'd1);

        // Random frames, some corrupted, some preceded by noise
        for (int it = 0; it < 25; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                for (int g = 0; g < int'($urandom_range(1, 2)); g++) begin
                    push_byte((pool[$urandom_range(0, 7)] == 8'h54) ? 8'h7A
                              : pool[$urandom_range(0, 7)]);
                end
            end
            h = $urandom_range(0, 29);
            m = ($urandom_range(0, 7) == 0) ? $urandom_range(60, 69) : $urandom_range(0, 59);
            s = $urandom_range(0, 59);
            frm[0] = 8'h54;
            frm[1] = 8'(48 + h / 10);
            frm[2] = 8'(48 + h % 10);
            frm[3] = 8'h3A;
            frm[4] = 8'(48 + m / 10);
            frm[5] = 8'(48 + m % 10);
            frm[6] = 8'h3A;
            frm[7] = 8'(48 + s / 10);
            frm[8] = 8'(48 + s % 10);
            frm[9] = $urandom_range(0, 1) ? 8'h0D : 8'h0A;
            if ($urandom_range(0, 3) == 0) frm[$urandom_range(1, 9)] = pool[$urandom_range(0, 7)];
            spacing = $urandom_range(0, 3);
            for (int i = 0; i < 10; i++) push_byte(frm[i]);
            drain($sformatf("rand%0d", it));
            finish_scn($sformatf("rand%0d", it));
        end

        // Reset in the middle of a frame, then a clean frame
        send_str("T12:3", 0);
        drain("midreset");
        check("midreset/busy_before", {31'b0, busy}, 32'd1);
        reset = 1'b1;
        fifo.delete();
        gap = 0;
        bus.empty = 1'b1;
        m_buf.delete();
        last_h = 0;
        last_m = 0;
        last_s = 0;
        #1;
        check_reset_outputs("midreset");
        repeat (2) step();
        reset = 1'b0;
        send_str("T00:00:00\015", 2);
        drain("after_reset");
        finish_scn("after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
